param_sequencer: RTL and testbench
==================================

Name: param_sequencer

Overview:
- Owns the 64-channel oscillator bank's control parameters: amplitude, offset and phase word per channel.
- Parses one 16-bit framed word stream from a host pipe endpoint and writes each word into a shadow register bank.
- Copies shadow to active on a commit request. The copy happens only at a frame boundary, so the bank never sees a half-loaded parameter set.
- Replaces per-pipe block counters and reset-triggered bank loading. Drives the bank's parameter buses and its phase-sync pulse.

Parameters:
- N_CH, 64, number of oscillator channels; power of two, max 64.
- W, 16, width of each parameter word.
- CH_W, 6, channel address width; equals log2(N_CH).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- word_in  in  16  stream word from host pipe.
- word_valid  in  1  word_in valid this cycle; no backpressure, every valid word is consumed.
- commit  in  1  single-cycle pulse: request shadow-to-active copy.
- flush  in  1  single-cycle pulse: abort current frame, reload shadow from active.
- active_amps  out  N_CH*W  channel c at [c*W +: W].
- active_offsets  out  N_CH*W  same packing.
- active_phasewords  out  N_CH*W  same packing.
- osc_sync  out  1  one-cycle pulse, same cycle active buses update; bank restarts its phase accumulators.
- commit_done  out  1  one-cycle pulse when a commit takes effect.
- busy  out  1  high whenever the state is not S_IDLE.
- err_target  out  1  sticky; set by a header with a reserved target; cleared only by reset.

Behaviour:
- Reset values: all shadow and active registers 0; every output 0; state S_IDLE; commit_pend 0.
- Header word fields:
  - [15:14] target: 00 amp, 01 offset, 10 phaseword, 11 reserved.
  - [13:8] start_ch.
  - [5:0] count-1, giving 1..64 data words.
  - [7:6] ignored.
- S_IDLE, valid word: latch header.
  - Target 11 → set err_target, go to S_SKIP.
  - Otherwise → S_DATA, with ch = start_ch and remaining = count.
- S_DATA, valid word: shadow[target][ch] <= word_in; ch <= (ch+1) mod N_CH, so channel writes wrap past 63 to 0; remaining decrements. The last word returns to S_IDLE.
- S_SKIP: consume and discard count words, then go to S_IDLE.
- Invalid cycles hold all state; there is no timeout.
- Commit handling:
  - commit in S_IDLE with no valid word that cycle → next cycle all three active buses <= shadow, osc_sync=1, commit_done=1.
  - commit while busy, or in the same cycle a header arrives → sets commit_pend.
  - The pended commit executes the cycle after the frame's final word, giving latency 1 from the final word.
  - Several commits while pending collapse into one.
- Flush: in any state, next cycle shadow <= active, state <= S_IDLE, commit_pend <= 0, no osc_sync. Flush wins over commit in the same cycle.
- Reset low mid-frame: everything returns to reset values immediately (asynchronous).
- Active registers change only on a commit; phases are never glitched mid-frame.

Optional Feature:
- Macro: PARAM_SEQ_CHECKSUM_EN.
- Defined:
  - Each frame carries one trailer word after its data. The trailer equals the sum mod 2^16 of the header plus all data words. Skipped frames also carry a trailer.
  - New state S_CSUM consumes the trailer.
  - On mismatch: set sticky output csum_err and set shadow_bad.
  - While shadow_bad, a commit (immediate or pending) is dropped: no osc_sync and no commit_done, and a commit_rej pulse is emitted instead.
  - Flush clears shadow_bad.
  - Ports csum_err and commit_rej exist only under the macro.
- Undefined: frames have no trailer; no S_CSUM state; commits are never rejected.

Decomposition:
- Shared package param_seq_pkg holds:
  - Target code constants TGT_AMP, TGT_OFF, TGT_PHW, TGT_RSV.
  - Header field bit positions.
  - State encoding S_IDLE, S_DATA, S_SKIP, S_CSUM.
- One natural sub-module: param_bank. It holds the N_CH×W shadow/active pair for a single parameter type, with write port (ch, data, we), a copy strobe and a flush strobe. It is instantiated three times; param_sequencer keeps only the FSM.

Test Plan:
- Header 0x0003 (amp, start 0, count 4), data 0x1111..0x4444, then commit → active_amps ch0..3 = 0x1111..0x4444; others 0; osc_sync and commit_done one cycle each.
- Header 0x7E01 (offset, start 62, count 2), data 0xAAAA, 0xBBBB, commit → offsets ch62 = 0xAAAA, ch63 = 0xBBBB; no other channel changes.
- Wrap-around: header 0x7F01 (offset, start 63, count 2), data 0xAAAA, 0xBBBB, commit → offsets ch63 = 0xAAAA, ch0 = 0xBBBB.
- Commit pulsed after header 0x8001 (phaseword, count 2) with only one data word sent → active unchanged and busy=1; after the 2nd word, active updates exactly 1 cycle later.
- Header 0xC002 (reserved) then 3 words, then header 0x0000 + 0x5555 + commit → err_target=1; the 3 words are not written; amp ch0 = 0x5555.
- Mid-frame flush after 1 of 4 data words, then commit → active unchanged, shadow equals active, no osc_sync from flush. With PARAM_SEQ_CHECKSUM_EN: a bad trailer then commit → commit_rej=1, active unchanged.

Source files
------------

// File: rtl/param_seq_pkg.sv
// Shared constants for the oscillator parameter sequencer: header fields, targets, FSM states.
// Checksum trailers are enabled by defining PARAM_SEQ_CHECKSUM_EN.
package param_seq_pkg;

  localparam logic [1:0] TGT_AMP = 2'b00;
  localparam logic [1:0] TGT_OFF = 2'b01;
  localparam logic [1:0] TGT_PHW = 2'b10;
  localparam logic [1:0] TGT_RSV = 2'b11;

  localparam int HDR_TGT_LSB = 14;
  localparam int HDR_CH_LSB  = 8;
  localparam int HDR_CNT_LSB = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_SKIP = 2'd2;
  localparam logic [1:0] S_CSUM = 2'd3;

  // Header carries count-1; the result spans 1..64.
  function automatic logic [6:0] hdr_count(input logic [15:0] hdr);
    return {1'b0, hdr[HDR_CNT_LSB +: 6]} + 7'd1;
  endfunction

endpackage

// File: rtl/param_seq_if.sv
// Host pipe stream into the parameter sequencer: framed words plus commit/flush strobes.
interface param_seq_if #(parameter int W = 16);
  logic [W-1:0] word_in;
  logic         word_valid;
  logic         commit;
  logic         flush;

  modport master (output word_in, word_valid, commit, flush);
  modport slave  (input  word_in, word_valid, commit, flush);
endinterface

// File: rtl/param_seq_bank.sv
// Shadow/active register pair for one parameter type across all channels.
module param_bank #(
  parameter int N_CH = 64,
  parameter int W    = 16,
  parameter int CH_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [CH_W-1:0]   ch,
  input  logic [W-1:0]      data,
  input  logic              copy,
  input  logic              flush,
  output logic [N_CH*W-1:0] active_bus
);

  logic [W-1:0] shadow_r [N_CH];
  logic [W-1:0] active_r [N_CH];

  // Flush restores shadow from active; copy publishes shadow to the bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        shadow_r[i] <= '0;
        active_r[i] <= '0;
      end
    end else begin
      if (flush) begin
        for (int i = 0; i < N_CH; i++) shadow_r[i] <= active_r[i];
      end else if (we) begin
        shadow_r[ch] <= data;
      end
      if (copy) begin
        for (int i = 0; i < N_CH; i++) active_r[i] <= shadow_r[i];
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_pack
    assign active_bus[g*W +: W] = active_r[g];
  end

endmodule

// File: rtl/param_sequencer.sv
// Frame parser and commit sequencer driving the oscillator bank parameter buses.
// Optional trailer checksum and commit rejection under PARAM_SEQ_CHECKSUM_EN.
module param_sequencer
  import param_seq_pkg::*;
#(
  parameter int N_CH = 64,
  parameter int W    = 16,
  parameter int CH_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  param_seq_if.slave        host,
  output logic [N_CH*W-1:0] active_amps,
  output logic [N_CH*W-1:0] active_offsets,
  output logic [N_CH*W-1:0] active_phasewords,
  output logic              osc_sync,
  output logic              commit_done,
  output logic              busy,
`ifdef PARAM_SEQ_CHECKSUM_EN
  output logic              csum_err,
  output logic              commit_rej,
`endif
  output logic              err_target
);

`ifdef PARAM_SEQ_CHECKSUM_EN
  localparam logic [1:0] S_END = S_CSUM;
`else
  localparam logic [1:0] S_END = S_IDLE;
`endif

  logic [1:0]      state_r, tgt_r;
  logic [CH_W-1:0] ch_r;
  logic [6:0]      rem_r;
  logic            pend_r, osc_sync_r, commit_done_r, err_target_r;
  logic            idle_s, exec_s, copy_s, pend_set_s, we_s;
  logic [2:0]      bank_we_s;
`ifdef PARAM_SEQ_CHECKSUM_EN
  logic [W-1:0]    csum_r;
  logic            shadow_bad_r, csum_err_r, commit_rej_r, rej_s;
`endif

  // Commit arbitration: immediate in idle, otherwise pended until the frame ends.
  always_comb begin
    idle_s     = (state_r == S_IDLE);
    exec_s     = idle_s && !host.flush && (pend_r || (host.commit && !host.word_valid));
    pend_set_s = host.commit && !host.flush && (!idle_s || host.word_valid);
    we_s       = (state_r == S_DATA) && host.word_valid && !host.flush;
`ifdef PARAM_SEQ_CHECKSUM_EN
    copy_s     = exec_s && !shadow_bad_r;
    rej_s      = exec_s && shadow_bad_r;
`else
    copy_s     = exec_s;
`endif
    bank_we_s[0] = we_s && (tgt_r == TGT_AMP);
    bank_we_s[1] = we_s && (tgt_r == TGT_OFF);
    bank_we_s[2] = we_s && (tgt_r == TGT_PHW);
  end

  // Frame parser FSM and pending-commit flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      tgt_r        <= 2'b00;
      ch_r         <= '0;
      rem_r        <= 7'd0;
      pend_r       <= 1'b0;
      err_target_r <= 1'b0;
    end else if (host.flush) begin
      state_r <= S_IDLE;
      pend_r  <= 1'b0;
    end else begin
      if (pend_set_s)  pend_r <= 1'b1;
      else if (exec_s) pend_r <= 1'b0;
      if (host.word_valid) begin
        case (state_r)
          S_IDLE: begin
            tgt_r <= host.word_in[HDR_TGT_LSB +: 2];
            ch_r  <= host.word_in[HDR_CH_LSB +: CH_W];
            rem_r <= hdr_count(host.word_in[15:0]);
            if (host.word_in[HDR_TGT_LSB +: 2] == TGT_RSV) begin
              err_target_r <= 1'b1;
              state_r      <= S_SKIP;
            end else begin
              state_r <= S_DATA;
            end
          end
          S_DATA, S_SKIP: begin
            ch_r  <= ch_r + {{(CH_W-1){1'b0}}, 1'b1};
            rem_r <= rem_r - 7'd1;
            if (rem_r == 7'd1) state_r <= S_END;
          end
          S_CSUM:  state_r <= S_IDLE;
          default: state_r <= S_IDLE;
        endcase
      end
    end
  end

`ifdef PARAM_SEQ_CHECKSUM_EN
  // Running trailer sum and sticky checksum error; flush clears only shadow_bad.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum_r       <= '0;
      shadow_bad_r <= 1'b0;
      csum_err_r   <= 1'b0;
      commit_rej_r <= 1'b0;
    end else begin
      commit_rej_r <= rej_s;
      if (host.flush) begin
        shadow_bad_r <= 1'b0;
      end else if (host.word_valid) begin
        if (state_r == S_IDLE) begin
          csum_r <= host.word_in;
        end else if (state_r == S_CSUM) begin
          if (host.word_in != csum_r) begin
            csum_err_r   <= 1'b1;
            shadow_bad_r <= 1'b1;
          end
        end else begin
          csum_r <= csum_r + host.word_in;
        end
      end
    end
  end

  assign csum_err   = csum_err_r;
  assign commit_rej = commit_rej_r;
`endif

  // Sync and done pulses coincide with the active-bus update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      osc_sync_r    <= 1'b0;
      commit_done_r <= 1'b0;
    end else begin
      osc_sync_r    <= copy_s;
      commit_done_r <= copy_s;
    end
  end

  param_bank #(.N_CH(N_CH), .W(W), .CH_W(CH_W)) u_amp (
    .clk(clk), .reset(reset), .we(bank_we_s[0]), .ch(ch_r), .data(host.word_in),
    .copy(copy_s), .flush(host.flush), .active_bus(active_amps));

  param_bank #(.N_CH(N_CH), .W(W), .CH_W(CH_W)) u_off (
    .clk(clk), .reset(reset), .we(bank_we_s[1]), .ch(ch_r), .data(host.word_in),
    .copy(copy_s), .flush(host.flush), .active_bus(active_offsets));

  param_bank #(.N_CH(N_CH), .W(W), .CH_W(CH_W)) u_phw (
    .clk(clk), .reset(reset), .we(bank_we_s[2]), .ch(ch_r), .data(host.word_in),
    .copy(copy_s), .flush(host.flush), .active_bus(active_phasewords));

  assign osc_sync    = osc_sync_r;
  assign commit_done = commit_done_r;
  assign busy        = !idle_s;
  assign err_target  = err_target_r;

endmodule

// File: tb/tb_param_sequencer.sv
// Self-checking bench for param_sequencer: vector table, hand corner cases, random frames vs model.
module tb_param_sequencer;
  import param_seq_pkg::*;

  localparam int N_CH = 64;
  localparam int W    = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  param_seq_if #(.W(W)) host();
  logic [N_CH*W-1:0] active_amps, active_offsets, active_phasewords;
  logic osc_sync, commit_done, busy, err_target;
`ifdef PARAM_SEQ_CHECKSUM_EN
  logic csum_err, commit_rej;
`endif

  param_sequencer #(.N_CH(N_CH), .W(W), .CH_W(6)) dut (
    .clk(clk), .reset(reset), .host(host),
    .active_amps(active_amps), .active_offsets(active_offsets),
    .active_phasewords(active_phasewords), .osc_sync(osc_sync),
    .commit_done(commit_done), .busy(busy),
`ifdef PARAM_SEQ_CHECKSUM_EN
    .csum_err(csum_err), .commit_rej(commit_rej),
`endif
    .err_target(err_target));

  int checks = 0;
  int errors = 0;
  logic [15:0] m_sh [3][N_CH];
  logic [15:0] m_ac [3][N_CH];
  bit          m_bad = 1'b0;
  logic [15:0] frame_q [$];
  bit          gaps = 1'b0;

  typedef struct {
    logic [15:0] hdr;
    int          n;
    logic [15:0] d0;
    logic [15:0] step;
    int          t;
    int          ch;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] dut_ch(input int t, input int c);
    case (t)
      0:       return active_amps[c*W +: W];
      1:       return active_offsets[c*W +: W];
      default: return active_phasewords[c*W +: W];
    endcase
  endfunction

  task automatic check_all(input string tag);
    for (int t = 0; t < 3; t++) begin
      int bad_ch = -1;
      for (int c = 0; c < N_CH; c++)
        if (bad_ch < 0 && dut_ch(t, c) !== m_ac[t][c]) bad_ch = c;
      checks++;
      if (bad_ch >= 0) begin
        errors++;
        $display("FAIL %s bus%0d ch%0d: got=%0h expected=%0h", tag, t, bad_ch,
                 dut_ch(t, bad_ch), m_ac[t][bad_ch]);
      end
    end
  endtask

  task automatic model_clear();
    for (int t = 0; t < 3; t++)
      for (int c = 0; c < N_CH; c++) begin
        m_sh[t][c] = 16'h0000;
        m_ac[t][c] = 16'h0000;
      end
    m_bad = 1'b0;
  endtask

  task automatic model_frame(input logic [15:0] hdr);
    int t = int'(hdr[15:14]);
    int st = int'(hdr[13:8]);
    if (t != 3)
      foreach (frame_q[i]) m_sh[t][(st + i) % N_CH] = frame_q[i];
  endtask

  task automatic model_commit();
    if (!m_bad)
      for (int t = 0; t < 3; t++)
        for (int c = 0; c < N_CH; c++) m_ac[t][c] = m_sh[t][c];
  endtask

  task automatic model_flush();
    for (int t = 0; t < 3; t++)
      for (int c = 0; c < N_CH; c++) m_sh[t][c] = m_ac[t][c];
    m_bad = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    if (gaps && $urandom_range(0, 3) == 0) tick();
    host.word_in    = w;
    host.word_valid = 1'b1;
    tick();
    host.word_valid = 1'b0;
    host.word_in    = 16'h0000;
  endtask

  task automatic send_frame(input logic [15:0] hdr, input bit bad_trl);
    logic [15:0] sum = hdr;
    send_word(hdr);
    foreach (frame_q[i]) begin
      send_word(frame_q[i]);
      sum = sum + frame_q[i];
    end
`ifdef PARAM_SEQ_CHECKSUM_EN
    send_word(bad_trl ? ~sum : sum);
`else
    if (bad_trl) sum = 16'h0000;
`endif
  endtask

  task automatic do_commit(input string tag);
    host.commit = 1'b1;
    tick();
    host.commit = 1'b0;
    model_commit();
    check1({tag, " osc_sync"}, {31'd0, osc_sync}, {31'd0, !m_bad});
    check1({tag, " commit_done"}, {31'd0, commit_done}, {31'd0, !m_bad});
`ifdef PARAM_SEQ_CHECKSUM_EN
    check1({tag, " commit_rej"}, {31'd0, commit_rej}, {31'd0, m_bad});
`endif
    check_all(tag);
    tick();
    check1({tag, " osc_sync drop"}, {31'd0, osc_sync}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    host.word_in = 16'h0000; host.word_valid = 1'b0;
    host.commit = 1'b0; host.flush = 1'b0;
    model_clear();
    vecs[0] = '{16'h0003, 4, 16'h1111, 16'h1111, 0, 3,  16'h4444};
    vecs[1] = '{16'h7E01, 2, 16'hAAAA, 16'h1111, 1, 62, 16'hAAAA};
    vecs[2] = '{16'h7F01, 2, 16'hAAAA, 16'h1111, 1, 0,  16'hBBBB};
    vecs[3] = '{16'h8005, 6, 16'h0100, 16'h0001, 2, 5,  16'h0105};

    #12;
    check1("reset busy", {31'd0, busy}, 32'd0);
    check1("reset osc_sync", {31'd0, osc_sync}, 32'd0);
    check1("reset commit_done", {31'd0, commit_done}, 32'd0);
    check1("reset err_target", {31'd0, err_target}, 32'd0);
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;
    tick();

    for (int v = 0; v < 4; v++) begin
      frame_q.delete();
      for (int i = 0; i < vecs[v].n; i++) frame_q.push_back(vecs[v].d0 + 16'(i) * vecs[v].step);
      send_frame(vecs[v].hdr, 1'b0);
      model_frame(vecs[v].hdr);
      do_commit($sformatf("vec%0d", v));
      check1($sformatf("vec%0d table ch", v), {16'd0, dut_ch(vecs[v].t, vecs[v].ch)},
             {16'd0, vecs[v].exp});
    end
    check1("wrap ch63", {16'd0, dut_ch(1, 63)}, 32'h0000AAAA);

    // Commit while a frame is partially loaded executes one cycle after its final word.
    frame_q = '{16'h0A0A, 16'h0B0B};
    send_word(16'h8001);
    send_word(16'h0A0A);
    host.commit = 1'b1;
    tick();
    host.commit = 1'b0;
    check1("pend busy", {31'd0, busy}, 32'd1);
    check1("pend osc_sync", {31'd0, osc_sync}, 32'd0);
    check_all("pend held");
    send_word(16'h0B0B);
`ifdef PARAM_SEQ_CHECKSUM_EN
    send_word(16'h8001 + 16'h0A0A + 16'h0B0B);
`endif
    check1("pend final osc_sync", {31'd0, osc_sync}, 32'd0);
    check_all("pend final");
    model_frame(16'h8001);
    tick();
    model_commit();
    check1("pend exec osc_sync", {31'd0, osc_sync}, 32'd1);
    check1("pend exec commit_done", {31'd0, commit_done}, 32'd1);
    check_all("pend exec");
    check1("pend phw ch1", {16'd0, dut_ch(2, 1)}, 32'h00000B0B);
    tick();

    // Reserved target: words skipped, sticky error.
    frame_q = '{16'h0001, 16'h0002, 16'h0003};
    send_frame(16'hC002, 1'b0);
    check1("rsv err_target", {31'd0, err_target}, 32'd1);
    check1("rsv busy", {31'd0, busy}, 32'd0);
    frame_q = '{16'h5555};
    send_frame(16'h0000, 1'b0);
    model_frame(16'h0000);
    do_commit("rsv");
    check1("rsv amp ch0", {16'd0, dut_ch(0, 0)}, 32'h00005555);

    // Uncommitted frame, then a flushed partial frame: shadow must revert to active.
    frame_q = '{16'h7777};
    send_frame(16'h0A00, 1'b0);
    model_frame(16'h0A00);
    send_word(16'h0003);
    send_word(16'hDEAD);
    host.flush = 1'b1;
    tick();
    host.flush = 1'b0;
    model_flush();
    check1("flush osc_sync", {31'd0, osc_sync}, 32'd0);
    check1("flush busy", {31'd0, busy}, 32'd0);
    do_commit("flush");
    check1("flush amp ch10", {16'd0, dut_ch(0, 10)}, {16'd0, m_ac[0][10]});

`ifdef PARAM_SEQ_CHECKSUM_EN
    frame_q = '{16'h1234};
    send_frame(16'h0500, 1'b1);
    model_frame(16'h0500);
    m_bad = 1'b1;
    check1("csum err", {31'd0, csum_err}, 32'd1);
    do_commit("csum reject");
    host.flush = 1'b1;
    tick();
    host.flush = 1'b0;
    model_flush();
    check1("csum err sticky", {31'd0, csum_err}, 32'd1);
    do_commit("csum after flush");
`endif

    gaps = 1'b1;
    for (int r = 0; r < 40; r++) begin
      int n = $urandom_range(1, 8);
      logic [15:0] hdr;
      hdr = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
             2'($urandom_range(0, 3)), 6'(n - 1)};
      frame_q.delete();
      for (int i = 0; i < n; i++) frame_q.push_back(16'($urandom));
      send_frame(hdr, 1'b0);
      model_frame(hdr);
      if (hdr[15:14] == 2'b11) check1("rand err_target", {31'd0, err_target}, 32'd1);
      if ($urandom_range(0, 1) == 1) do_commit($sformatf("rand%0d", r));
    end
    gaps = 1'b0;
    do_commit("rand final");

    // Asynchronous reset in the middle of a frame.
    send_word(16'h0003);
    send_word(16'h9999);
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check1("async rst busy", {31'd0, busy}, 32'd0);
    check1("async rst err_target", {31'd0, err_target}, 32'd0);
    check_all("async rst");
    @(negedge clk);
    reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
